// File: rtl/word_fifo_pkg.sv
// Shared widths and types for the word FIFO.
package word_fifo_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/word_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port, synchronously cleared to zero.
module word_fifo_mem
  import word_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
// Flags and count are registered; the head word is read straight from storage.
module word_fifo
  import word_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, count_n;
  logic          push, pop;
  logic          full_n, empty_n;

  // Handshakes depend only on registered flags, never on the opposite side.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // Next pointers, occupancy and flags; extra pointer MSB separates full from empty.
  always_comb begin
    wr_ptr_n = wr_ptr + PW'(push);
    rd_ptr_n = rd_ptr + PW'(pop);
    count_n  = count;
    if (push && !pop) begin
      count_n = count + PW'(1);
    end else if (pop && !push) begin
      count_n = count - PW'(1);
    end
    full_n  = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
              (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    empty_n = (wr_ptr_n == rd_ptr_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= full_n;
      empty  <= empty_n;
    end
  end

  word_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(out_data)
  );

endmodule
